// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS run-control block.
// Holds the sequencer state encoding used by RTL and bench alike.
package picomips_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    SHOW  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/picomips_io_ctrl_if.sv
// Start/done handshake between the run-control sequencer and the core.
// master = sequencer side, slave = core side.
interface picomips_io_ctrl_if #(
  parameter int DATA_W = 8
);

  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_index;
  logic [DATA_W-1:0] core_result;

  modport master (
    output core_start,
    output core_index,
    input  core_done,
    input  core_result
  );

  modport slave (
    input  core_start,
    input  core_index,
    output core_done,
    output core_result
  );

endinterface

// File: rtl/picomips_io_ctrl_sw_debounce.sv
// One-bit switch synchroniser and debouncer with rise detect.
// low_o flags a genuinely observed, settled low once the chain has filled.
module sw_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic low_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   level_q;
  logic                   level_d;
  logic                   prev_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prime_q <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;
  // Reset-time zeros in the chain must not count as a seen low.
  assign low_o   = prime_q[SYNC_STAGES-1] & ~synced & ~level_q;

endmodule

// File: rtl/picomips_io_ctrl.sv
// Run-control sequencer between board switches/LEDs and the picoMIPS core.
// Debounced go rise latches the index, pulses start, waits for done.
module picomips_io_ctrl
  import picomips_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W:0]   sw_in,
  picomips_io_ctrl_if.master core,
  output logic [DATA_W-1:0] LED,
  output logic              timeout_err,
  output logic [2:0]        state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic              armed_q;
  logic              armed_d;
  logic [TW-1:0]     cnt_q;
  logic [TW-1:0]     cnt_d;
  logic [DATA_W-1:0] index_q;
  logic [DATA_W-1:0] index_d;
  logic [DATA_W-1:0] led_q;
  logic [DATA_W-1:0] led_d;
  logic              tmo_q;
  logic              tmo_d;

  logic [DATA_W-1:0] idx_sync_q [SYNC_STAGES];
  logic              go_level;
  logic              go_rise;
  logic              go_low;

  sw_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_go (
    .clk     (clk),
    .reset   (reset),
    .d_i     (sw_in[DATA_W]),
    .level_o (go_level),
    .rise_o  (go_rise),
    .low_o   (go_low)
  );

  // Index bits are only sampled in LATCH, so no debounce needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        idx_sync_q[i] <= '0;
      end
    end else begin
      idx_sync_q[0] <= sw_in[DATA_W-1:0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        idx_sync_q[i] <= idx_sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      index_q <= '0;
      led_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      led_q   <= led_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    led_d   = led_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (go_low) begin
          armed_d = 1'b1;
        end
        if (go_rise && armed_q) begin
          armed_d = 1'b0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        index_d = idx_sync_q[SYNC_STAGES-1];
        tmo_d   = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over a coincident timeout
        if (core.core_done) begin
          led_d   = core.core_result;
          state_d = SHOW;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (!go_level) begin
          armed_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core.core_start = (state_q == START);
  assign core.core_index = index_q;
  assign LED             = led_q;
  assign timeout_err     = tmo_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_picomips_io_ctrl.sv
// Self-checking bench for picomips_io_ctrl.
// Expected run outcomes are queued at go time and popped at SHOW.
module tb_picomips_io_ctrl;
  import picomips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] sw_in;
  logic [7:0] LED;
  logic       timeout_err;
  logic [2:0] state_o;

  picomips_io_ctrl_if #(.DATA_W(8)) core_if ();

  picomips_io_ctrl #(
    .DATA_W          (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (255)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_in       (sw_in),
    .core        (core_if),
    .LED         (LED),
    .timeout_err (timeout_err),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] led;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   starts = 0;

  always @(negedge clk) begin
    if (core_if.core_start === 1'b1) starts++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic release_go(input string tag);
    int  n;
    bit  ok;
    sw_in[8] = 1'b0;
    n  = 0;
    ok = 0;
    while (!ok && n < 30) begin
      @(negedge clk);
      n++;
      ok = (state_o == IDLE);
    end
    chk({tag, "_idle"}, 32'(ok), 1);
  endtask

  task automatic do_run(input logic [7:0] idx,
                        input int         done_at,
                        input logic [7:0] res,
                        input logic [7:0] exp_led,
                        input logic       exp_tmo,
                        input bit         glitch,
                        input string      tag);
    int   n;
    int   s0;
    bit   seen;
    exp_t e;
    sw_in = {1'b0, idx};
    repeat (15) @(negedge clk);
    sb.push_back('{idx: idx, led: exp_led, tmo: exp_tmo});
    s0    = starts;
    sw_in = {1'b1, idx};
    n     = 0;
    seen  = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = (core_if.core_start === 1'b1);
    end
    chk({tag, "_lat"}, 32'(seen && n <= 9), 1);
    if (!seen) begin
      e = sb.pop_front();
      return;
    end
    if (glitch) begin
      core_if.core_done   = 1'b1;
      core_if.core_result = 8'hEE;
    end
    sw_in = {1'b1, ~idx};
    n     = 0;
    seen  = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      core_if.core_done = 1'b0;
      if (state_o == SHOW) begin
        seen = 1;
      end else if (n == done_at) begin
        core_if.core_done   = 1'b1;
        core_if.core_result = res;
      end
    end
    core_if.core_done = 1'b0;
    chk({tag, "_show"}, 32'(seen), 1);
    if (done_at == 0) chk({tag, "_wlen"}, n, 256);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_idx"}, core_if.core_index, e.idx);
    chk({tag, "_led"}, LED, e.led);
    chk({tag, "_tmo"}, timeout_err, e.tmo);
    chk({tag, "_nst"}, starts - s0, 1);
  endtask

  initial begin
    int  s0;
    int  n;
    bit  seen;
    sw_in               = 9'h1FF;
    core_if.core_done   = 1'b0;
    core_if.core_result = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, IDLE);
    chk("rst_led", LED, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_idx", core_if.core_index, 0);
    chk("rst_start", core_if.core_start, 0);

    // T1: go held high through reset release
    reset = 1'b1;
    repeat (300) @(negedge clk);
    chk("t1_nst", starts, 0);
    chk("t1_state", state_o, IDLE);
    chk("t1_led", LED, 0);

    // T2: normal run
    do_run(8'h14, 10, 8'h5A, 8'h5A, 1'b0, 1'b0, "t2");
    chk("t2_state", state_o, SHOW);
    release_go("t2");

    // T3: glitch shorter than debounce window
    repeat (15) @(negedge clk);
    s0       = starts;
    sw_in[8] = 1'b1;
    repeat (2) @(negedge clk);
    sw_in[8] = 1'b0;
    repeat (30) @(negedge clk);
    chk("t3_nst", starts - s0, 0);
    chk("t3_state", state_o, IDLE);

    // T4: timeout with done pulse during START, then clean rerun
    do_run(8'h99, 0, 8'h00, 8'h5A, 1'b1, 1'b1, "t4a");
    release_go("t4a");
    do_run(8'h42, 3, 8'h77, 8'h77, 1'b0, 1'b0, "t4b");
    release_go("t4b");

    // T5: reset during WAIT
    sw_in = 9'h055;
    repeat (15) @(negedge clk);
    sw_in = 9'h155;
    n     = 0;
    seen  = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = (core_if.core_start === 1'b1);
    end
    chk("t5_start", 32'(seen), 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_led", LED, 0);
    chk("t5_idx", core_if.core_index, 0);
    chk("t5_state", state_o, IDLE);
    chk("t5_cst", core_if.core_start, 0);
    @(negedge clk);
    reset = 1'b1;
    s0    = starts;
    repeat (300) @(negedge clk);
    chk("t5_nst", starts - s0, 0);
    chk("t5_idle", state_o, IDLE);
    do_run(8'h21, 10, 8'h3C, 8'h3C, 1'b0, 1'b0, "t5b");
    release_go("t5b");

    // T6: done on the last timeout cycle
    do_run(8'h0F, 255, 8'hC3, 8'hC3, 1'b0, 1'b0, "t6");
    release_go("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
